// File: rtl/known_ch_table_pkg.sv
// Shared types, constants and the CH ordering function for the known-CH table.
// Entry fields are WORD_W wide; the table top is built with WORD_WIDTH equal to it.
package kch_pkg;

   localparam int WORD_W = 16;
   localparam logic [WORD_W-1:0] HOPS_INVALID = 16'hFFFF;
   localparam logic [WORD_W-1:0] Q_ONE        = 16'h4000;

   typedef struct packed {
      logic              valid;
      logic [WORD_W-1:0] id;
      logic [WORD_W-1:0] hops;
      logic [WORD_W-1:0] qvalue;
   } ch_entry_t;

   typedef enum logic [2:0] {
      S_IDLE,
      S_SEARCH,
      S_WRITE,
      S_SELECT,
      S_LOAD
   } kch_state_e;

   // True when a is strictly preferable to b: higher Q, then fewer hops, then lower ID.
   // An invalid entry is never preferable; any valid entry beats an invalid one.
   function automatic logic ch_better(input ch_entry_t a, input ch_entry_t b);
      if (!a.valid) return 1'b0;
      if (!b.valid) return 1'b1;
      if (a.qvalue != b.qvalue) return a.qvalue > b.qvalue;
      if (a.hops != b.hops) return a.hops < b.hops;
      return a.id < b.id;
   endfunction

endpackage

// File: rtl/known_ch_table_if.sv
// Heartbeat, advertisement and best-CH result signals of the known-CH table.
interface known_ch_table_if #(
   parameter int WORD_WIDTH = 16,
   parameter int MAX_CH     = 8
);
   localparam int IDX_W = (MAX_CH > 1) ? $clog2(MAX_CH) : 1;

   logic                  HB_reset;
   logic [WORD_WIDTH-1:0] HB_CHlimit;
   logic                  en_KCH;
   logic [WORD_WIDTH-1:0] fCH_ID;
   logic [WORD_WIDTH-1:0] fCH_Hops;
   logic [WORD_WIDTH-1:0] fCH_QValue;
   logic [WORD_WIDTH-1:0] chosenCH;
   logic [WORD_WIDTH-1:0] hopsfromCH;
   logic [WORD_WIDTH-1:0] chosenQ;
   logic [IDX_W:0]        ch_count;
   logic                  kch_valid;
   logic                  busy;
   logic                  kch_update;
   logic                  kch_drop;

   modport master (
      output HB_reset, HB_CHlimit, en_KCH, fCH_ID, fCH_Hops, fCH_QValue,
      input  chosenCH, hopsfromCH, chosenQ, ch_count, kch_valid, busy, kch_update, kch_drop
   );

   modport slave (
      input  HB_reset, HB_CHlimit, en_KCH, fCH_ID, fCH_Hops, fCH_QValue,
      output chosenCH, hopsfromCH, chosenQ, ch_count, kch_valid, busy, kch_update, kch_drop
   );

endinterface

// File: rtl/known_ch_table_scan_cmp.sv
// Single-cycle CH ordering comparator shared by the worst-entry search and best-entry select scans.
module kch_scan_cmp
   import kch_pkg::*;
(
   input  ch_entry_t a,
   input  ch_entry_t b,
   output logic      better
);

   assign better = ch_better(a, b);

endmodule

// File: rtl/known_ch_table.sv
// Table of up to MAX_CH cluster heads per heartbeat round with sequential best-CH selection.
// Define KCH_EVICT_EN to let a stronger new CH replace the worst entry of a full table.
module known_ch_table
   import kch_pkg::*;
#(
   parameter int WORD_WIDTH = WORD_W,
   parameter int MAX_CH     = 8
) (
   input logic             clk,
   input logic             nrst,
   known_ch_table_if.slave bus
);

   localparam int IDX_W = (MAX_CH > 1) ? $clog2(MAX_CH) : 1;
   localparam int CNT_W = IDX_W + 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(MAX_CH - 1);

   kch_state_e        state;
   ch_entry_t         tbl [MAX_CH];
   ch_entry_t         cand;
   ch_entry_t         ref_e;
   ch_entry_t         cur;
   ch_entry_t         cmp_a;
   ch_entry_t         cmp_b;
   logic              better;
   logic [IDX_W-1:0]  scan_idx;
   logic [IDX_W-1:0]  match_idx;
   logic [IDX_W-1:0]  free_idx;
   logic [IDX_W-1:0]  worst_idx;
   logic              match_found;
   logic              free_found;
   logic [CNT_W-1:0]  count;
   logic [CNT_W-1:0]  limit;
   logic [CNT_W-1:0]  limit_in;

   logic [WORD_W-1:0] chosen_id;
   logic [WORD_W-1:0] chosen_hops;
   logic [WORD_W-1:0] chosen_q;
   logic [CNT_W-1:0]  count_out;
   logic              valid_out;
   logic              busy_r;
   logic              update_r;
   logic              drop_r;

   assign cur      = tbl[scan_idx];
   assign limit_in = (bus.HB_CHlimit > WORD_WIDTH'(MAX_CH)) ? CNT_W'(MAX_CH)
                                                              : CNT_W'(bus.HB_CHlimit);

   // ref_e holds the running worst entry while searching and the running best while selecting
   always_comb begin
      cmp_a = cur;
      cmp_b = ref_e;
      if (state == S_SEARCH) begin
         cmp_a = ref_e;
         cmp_b = cur;
      end
   end

   kch_scan_cmp u_cmp (
      .a      (cmp_a),
      .b      (cmp_b),
      .better (better)
   );

   always_ff @(posedge clk) begin
      if (!nrst || bus.HB_reset) begin
         for (int unsigned i = 0; i < MAX_CH; i++) tbl[i] <= '0;
         limit       <= nrst ? limit_in : '0;
         state       <= S_IDLE;
         count       <= '0;
         cand        <= '0;
         ref_e       <= '0;
         scan_idx    <= '0;
         match_idx   <= '0;
         free_idx    <= '0;
         worst_idx   <= '0;
         match_found <= 1'b0;
         free_found  <= 1'b0;
         chosen_id   <= '0;
         chosen_hops <= HOPS_INVALID;
         chosen_q    <= '0;
         count_out   <= '0;
         valid_out   <= 1'b0;
         busy_r      <= 1'b0;
         update_r    <= 1'b0;
         drop_r      <= 1'b0;
      end else begin
         update_r <= 1'b0;
         drop_r   <= bus.en_KCH && (state != S_IDLE);
         case (state)
            S_IDLE: begin
               if (bus.en_KCH) begin
                  if (bus.fCH_Hops == HOPS_INVALID || limit == '0) begin
                     drop_r <= 1'b1;
                  end else begin
                     cand        <= '{valid: 1'b1, id: bus.fCH_ID, hops: bus.fCH_Hops,
                                      qvalue: bus.fCH_QValue};
                     ref_e       <= '0;
                     scan_idx    <= '0;
                     match_found <= 1'b0;
                     free_found  <= 1'b0;
                     busy_r      <= 1'b1;
                     state       <= S_SEARCH;
                  end
               end
            end
            S_SEARCH: begin
               if (cur.valid && cur.id == cand.id) begin
                  match_found <= 1'b1;
                  match_idx   <= scan_idx;
               end
               if (!cur.valid && !free_found) begin
                  free_found <= 1'b1;
                  free_idx   <= scan_idx;
               end
               if (cur.valid && (!ref_e.valid || better)) begin
                  ref_e     <= cur;
                  worst_idx <= scan_idx;
               end
               if (scan_idx == LAST_IDX) begin
                  scan_idx <= '0;
                  state    <= S_WRITE;
               end else begin
                  scan_idx <= scan_idx + 1'b1;
               end
            end
            S_WRITE: begin
               ref_e <= '0;
               state <= S_SELECT;
               if (match_found) begin
                  tbl[match_idx].hops   <= cand.hops;
                  tbl[match_idx].qvalue <= cand.qvalue;
               end else if (count < limit) begin
                  tbl[free_idx] <= cand;
                  count         <= count + CNT_W'(1);
               end else begin
`ifdef KCH_EVICT_EN
                  if (cand.qvalue > ref_e.qvalue) begin
                     tbl[worst_idx] <= cand;
                  end else begin
                     drop_r <= 1'b1;
                     busy_r <= 1'b0;
                     state  <= S_IDLE;
                  end
`else
                  drop_r <= 1'b1;
                  busy_r <= 1'b0;
                  state  <= S_IDLE;
`endif
               end
            end
            S_SELECT: begin
               if (better) ref_e <= cur;
               if (scan_idx == LAST_IDX) begin
                  scan_idx <= '0;
                  state    <= S_LOAD;
               end else begin
                  scan_idx <= scan_idx + 1'b1;
               end
            end
            S_LOAD: begin
               chosen_id   <= ref_e.id;
               chosen_hops <= ref_e.hops;
               chosen_q    <= ref_e.qvalue;
               count_out   <= count;
               valid_out   <= ref_e.valid;
               update_r    <= 1'b1;
               busy_r      <= 1'b0;
               state       <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   assign bus.chosenCH   = chosen_id;
   assign bus.hopsfromCH = chosen_hops;
   assign bus.chosenQ    = chosen_q;
   assign bus.ch_count   = count_out;
   assign bus.kch_valid  = valid_out;
   assign bus.busy       = busy_r;
   assign bus.kch_update = update_r;
   assign bus.kch_drop   = drop_r;

endmodule

// File: tb/tb_known_ch_table.sv
// Randomized bench for known_ch_table against a transaction-level table model, plus literal anchors.
module tb_known_ch_table;

   localparam int M = 8;
   localparam int W = 16;

   logic clk = 1'b0;
   logic nrst;
   always #5 clk = ~clk;

   known_ch_table_if #(.WORD_WIDTH(W), .MAX_CH(M)) bus ();

   known_ch_table #(.WORD_WIDTH(W), .MAX_CH(M)) dut (
      .clk  (clk),
      .nrst (nrst),
      .bus  (bus)
   );

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   // Model: table contents, and what the outputs must be each cycle
   bit          mv  [M];
   logic [15:0] mid [M];
   logic [15:0] mh  [M];
   logic [15:0] mq  [M];
   int          m_limit = 0;
   bit          pending = 0;
   bit          was_pending;
   int          cyc = 0;
   int          done_cyc = 0;
   bit          p_fail;
   logic [15:0] p_id, p_h, p_q;
   int          p_cnt;
   bit          armed = 0;

   logic [15:0] e_chosen, e_hops, e_q;
   int          e_count;
   logic        e_valid, e_busy, e_update, e_drop;

   function automatic logic [47:0] rank(input logic [15:0] q, input logic [15:0] h,
                                        input logic [15:0] id);
      return {q, ~h, ~id};
   endfunction

   task automatic model_accept(input logic [15:0] id, input logic [15:0] h, input logic [15:0] q);
      int slot = -1;
      int cnt  = 0;
      int b    = -1;
      for (int i = 0; i < M; i++) begin
         if (mv[i]) begin
            cnt++;
            if (mid[i] == id) slot = i;
         end
      end
      p_fail = 1'b0;
      if (slot >= 0) begin
         mh[slot] = h;
         mq[slot] = q;
      end else if (cnt < m_limit) begin
         for (int i = 0; i < M; i++) if (!mv[i] && slot < 0) slot = i;
         mv[slot]  = 1'b1;
         mid[slot] = id;
         mh[slot]  = h;
         mq[slot]  = q;
         cnt++;
      end else begin
`ifdef KCH_EVICT_EN
         int w = -1;
         for (int i = 0; i < M; i++)
            if (mv[i] && (w < 0 || rank(mq[i], mh[i], mid[i]) < rank(mq[w], mh[w], mid[w]))) w = i;
         if (q > mq[w]) begin
            mid[w] = id;
            mh[w]  = h;
            mq[w]  = q;
         end else begin
            p_fail = 1'b1;
         end
`else
         p_fail = 1'b1;
`endif
      end
      for (int i = 0; i < M; i++)
         if (mv[i] && (b < 0 || rank(mq[i], mh[i], mid[i]) > rank(mq[b], mh[b], mid[b]))) b = i;
      p_id     = mid[b];
      p_h      = mh[b];
      p_q      = mq[b];
      p_cnt    = cnt;
      done_cyc = cyc + (p_fail ? M + 1 : 2 * M + 2);
   endtask

   always @(posedge clk) begin
      cyc++;
      e_update = 1'b0;
      e_drop   = 1'b0;
      if (!nrst || bus.HB_reset) begin
         if (!nrst) armed = 1'b1;
         for (int i = 0; i < M; i++) mv[i] = 1'b0;
         m_limit  = !nrst ? 0 : ((bus.HB_CHlimit > M) ? M : int'(bus.HB_CHlimit));
         pending  = 1'b0;
         e_chosen = 16'h0;
         e_hops   = 16'hFFFF;
         e_q      = 16'h0;
         e_count  = 0;
         e_valid  = 1'b0;
         e_busy   = 1'b0;
      end else begin
         was_pending = pending;
         if (bus.en_KCH && was_pending) e_drop = 1'b1;
         if (was_pending && cyc == done_cyc) begin
            pending = 1'b0;
            e_busy  = 1'b0;
            if (p_fail) begin
               e_drop = 1'b1;
            end else begin
               e_chosen = p_id;
               e_hops   = p_h;
               e_q      = p_q;
               e_count  = p_cnt;
               e_valid  = 1'b1;
               e_update = 1'b1;
            end
         end
         if (bus.en_KCH && !was_pending) begin
            if (bus.fCH_Hops == 16'hFFFF || m_limit == 0) begin
               e_drop = 1'b1;
            end else begin
               model_accept(bus.fCH_ID, bus.fCH_Hops, bus.fCH_QValue);
               pending = 1'b1;
               e_busy  = 1'b1;
            end
         end
      end
   end

   always @(negedge clk) begin
      if (armed) begin
         chk("chosenCH",   32'(bus.chosenCH),   32'(e_chosen));
         chk("hopsfromCH", 32'(bus.hopsfromCH), 32'(e_hops));
         chk("chosenQ",    32'(bus.chosenQ),    32'(e_q));
         chk("ch_count",   32'(bus.ch_count),   32'(e_count));
         chk("kch_valid",  32'(bus.kch_valid),  32'(e_valid));
         chk("busy",       32'(bus.busy),       32'(e_busy));
         chk("kch_update", 32'(bus.kch_update), 32'(e_update));
         chk("kch_drop",   32'(bus.kch_drop),   32'(e_drop));
      end
   end

   // All driver tasks are entered and left on a falling edge
   task automatic adv(input logic [15:0] id, input logic [15:0] h, input logic [15:0] q);
      bus.en_KCH     = 1'b1;
      bus.fCH_ID     = id;
      bus.fCH_Hops   = h;
      bus.fCH_QValue = q;
      @(negedge clk);
      bus.en_KCH = 1'b0;
   endtask

   task automatic hb(input logic [15:0] lim);
      bus.HB_reset   = 1'b1;
      bus.HB_CHlimit = lim;
      @(negedge clk);
      bus.HB_reset = 1'b0;
   endtask

   task automatic wait_update(input string tag);
      repeat (2 * M + 1) @(negedge clk);
      chk({tag, "_busy_before"}, 32'(bus.busy), 32'd1);
      chk({tag, "_upd_before"}, 32'(bus.kch_update), 32'd0);
      @(negedge clk);
      chk({tag, "_upd"}, 32'(bus.kch_update), 32'd1);
      chk({tag, "_busy_after"}, 32'(bus.busy), 32'd0);
   endtask

   task automatic chk_cleared(input string tag);
      chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
      chk({tag, "_count"}, 32'(bus.ch_count), 32'd0);
      chk({tag, "_id"}, 32'(bus.chosenCH), 32'd0);
      chk({tag, "_hops"}, 32'(bus.hopsfromCH), 32'hFFFF);
      chk({tag, "_q"}, 32'(bus.chosenQ), 32'd0);
      chk({tag, "_valid"}, 32'(bus.kch_valid), 32'd0);
   endtask

   initial begin
      nrst           = 1'b0;
      bus.HB_reset   = 1'b0;
      bus.HB_CHlimit = '0;
      bus.en_KCH     = 1'b0;
      bus.fCH_ID     = '0;
      bus.fCH_Hops   = '0;
      bus.fCH_QValue = '0;
      repeat (3) @(negedge clk);
      chk_cleared("reset");
      chk("reset_upd", 32'(bus.kch_update), 32'd0);
      chk("reset_drop", 32'(bus.kch_drop), 32'd0);
      nrst = 1'b1;
      hb(16'd3);

      adv(16'd23, 16'd2, 16'h3000);
      wait_update("ins23");
      chk("ins23_id", 32'(bus.chosenCH), 32'd23);
      chk("ins23_hops", 32'(bus.hopsfromCH), 32'd2);
      chk("ins23_count", 32'(bus.ch_count), 32'd1);
      chk("ins23_valid", 32'(bus.kch_valid), 32'd1);

      adv(16'd45, 16'd2, 16'h2000);
      wait_update("ins45");
      chk("ins45_id", 32'(bus.chosenCH), 32'd23);
      chk("ins45_count", 32'(bus.ch_count), 32'd2);

      adv(16'd12, 16'd1, 16'h4000);
      wait_update("ins12");
      chk("ins12_id", 32'(bus.chosenCH), 32'd12);
      chk("ins12_q", 32'(bus.chosenQ), 32'h4000);
      chk("ins12_count", 32'(bus.ch_count), 32'd3);

      adv(16'd6, 16'd1, 16'h4000);
`ifdef KCH_EVICT_EN
      wait_update("evict6");
      chk("evict6_id", 32'(bus.chosenCH), 32'd6);
      chk("evict6_count", 32'(bus.ch_count), 32'd3);
`else
      repeat (M) @(negedge clk);
      chk("full6_nodrop_yet", 32'(bus.kch_drop), 32'd0);
      @(negedge clk);
      chk("full6_drop", 32'(bus.kch_drop), 32'd1);
      chk("full6_busy", 32'(bus.busy), 32'd0);
      chk("full6_id", 32'(bus.chosenCH), 32'd12);
`endif

      adv(16'd23, 16'd1, 16'h7000);
      wait_update("upd23");
      chk("upd23_id", 32'(bus.chosenCH), 32'd23);
      chk("upd23_hops", 32'(bus.hopsfromCH), 32'd1);
      chk("upd23_count", 32'(bus.ch_count), 32'd3);

      adv(16'd12, 16'd1, 16'h4000);
      wait_update("resend12");
      chk("resend12_count", 32'(bus.ch_count), 32'd3);
      chk("resend12_id", 32'(bus.chosenCH), 32'd23);

      adv(16'd50, 16'd3, 16'h1000);
      adv(16'd51, 16'd1, 16'hF000);
      chk("busy_drop", 32'(bus.kch_drop), 32'd1);
      repeat (2 * M + 2) @(negedge clk);
      chk("busy_drop_id", 32'(bus.chosenCH), 32'd23);
      chk("busy_drop_count", 32'(bus.ch_count), 32'd3);

      adv(16'd60, 16'hFFFF, 16'h5000);
      chk("inv_hops_drop", 32'(bus.kch_drop), 32'd1);
      chk("inv_hops_busy", 32'(bus.busy), 32'd0);

      adv(16'd70, 16'd1, 16'h1000);
      repeat (3) @(negedge clk);
      hb(16'd5);
      chk_cleared("hb_abort");

      adv(16'd71, 16'd2, 16'h2000);
      repeat (M + 3) @(negedge clk);
      nrst = 1'b0;
      @(negedge clk);
      chk_cleared("nrst_abort");
      nrst = 1'b1;
      hb(16'd4);

      for (int k = 0; k < 3000; k++) begin
         nrst           = ($urandom_range(0, 249) != 0);
         bus.HB_reset   = ($urandom_range(0, 89) == 0);
         bus.HB_CHlimit = 16'($urandom_range(0, 10));
         bus.en_KCH     = ($urandom_range(0, 4) == 0);
         bus.fCH_ID     = 16'($urandom_range(0, 11));
         bus.fCH_Hops   = ($urandom_range(0, 9) == 0) ? 16'hFFFF : 16'($urandom_range(0, 3));
         bus.fCH_QValue = 16'($urandom_range(0, 4) * 16'h1000);
         @(negedge clk);
      end
      nrst         = 1'b1;
      bus.HB_reset = 1'b0;
      bus.en_KCH   = 1'b0;
      repeat (2 * M + 4) @(negedge clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/known_ch_table.md
Name: known_ch_table

Overview:
- Parametrised successor to the single-best known-CH tracker.
- Keeps a table of up to MAX_CH cluster heads (ID, hops, Q-value) learned from CH advertisements within one heartbeat round.
- Updates entries in place by ID and enforces the per-round CH limit taken from the heartbeat.
- After every change it sequentially selects the best CH and drives it to the routing/transmit path.

Parameters:
- WORD_WIDTH, 16, width of ID, hops and Q-value fields.
- MAX_CH, 8, physical table depth (≥2).
- IDX_W, $clog2(MAX_CH), index/count width (derived; do not override).

Ports:
- clk  in  1  clock
- nrst  in  1  synchronous active-low reset
- HB_reset  in  1  heartbeat pulse: clear table, latch limit
- HB_CHlimit  in  WORD_WIDTH  max CHs accepted this round, sampled on HB_reset
- en_KCH  in  1  one-cycle strobe: fCH_* valid
- fCH_ID  in  WORD_WIDTH  advertised CH node ID
- fCH_Hops  in  WORD_WIDTH  advertised hop count; 0xFFFF means invalid
- fCH_QValue  in  WORD_WIDTH  unsigned Q2.14 (0x4000 = 1.0)
- chosenCH  out  WORD_WIDTH  best CH ID
- hopsfromCH  out  WORD_WIDTH  hops of best CH
- chosenQ  out  WORD_WIDTH  Q-value of best CH
- ch_count  out  IDX_W+1  valid entries
- kch_valid  out  1  at least one entry, selection current
- busy  out  1  operation in progress
- kch_update  out  1  one-cycle pulse when outputs refreshed
- kch_drop  out  1  one-cycle pulse when an advertisement is discarded

Behaviour:
- Reset (nrst=0 at a clock edge): all entries invalid; limit=0; FSM=IDLE.
  - Outputs: chosenCH=0, hopsfromCH=0xFFFF, chosenQ=0, ch_count=0, kch_valid=0, busy=0, kch_update=0, kch_drop=0.
- HB_reset=1: next cycle, same cleared state as reset.
  - Except limit = min(HB_CHlimit, MAX_CH).
  - Aborts any in-progress operation.
  - Wins over a same-cycle en_KCH; that en_KCH is dropped silently (no kch_drop).
- FSM states:
  - IDLE: en_KCH accepted only here.
    - If fCH_Hops==0xFFFF or limit==0: kch_drop pulses next cycle, stay IDLE.
    - Otherwise latch fCH_* and go to SEARCH; busy=1 from the next cycle.
  - SEARCH (MAX_CH cycles, one entry per cycle): record matching-ID index, first free index, and worst valid index.
    - Worst = lowest Q; ties broken by highest hops, then highest ID.
  - WRITE (1 cycle):
    - Match found: overwrite hops/Q; count unchanged.
    - No match and ch_count<limit: write to free slot; count+1.
    - Otherwise: table full, see Optional Feature.
  - SELECT (MAX_CH cycles): best = highest Q; ties broken by lowest hops, then lowest ID.
  - Next cycle: outputs load best; kch_update=1; busy=0; return to IDLE.
- Latency: en_KCH accepted at edge t → kch_update at edge t+2*MAX_CH+2. Back-to-back acceptance is possible on the cycle busy falls.
- en_KCH while busy: discarded; kch_drop pulses next cycle; table untouched.
- Outputs hold their last values during busy; they never show partial scan results.
- Comparisons are unsigned. Q-value and hops are stored verbatim, with no arithmetic on them.
- Lowering the limit requires HB_reset, so ch_count never exceeds limit.

Optional Feature:
- Macro KCH_EVICT_EN.
- Defined: on a full table with no ID match, the new CH replaces the worst entry if its Q is strictly greater than the worst entry's Q.
  - Equal or lower Q: dropped with a kch_drop pulse.
  - Eviction still proceeds through SELECT/kch_update.
- Undefined: a new ID on a full table is always dropped.
  - kch_drop pulses when WRITE would occur; the FSM then returns to IDLE with no kch_update and outputs unchanged.

Decomposition:
- Shared package kch_pkg:
  - typedef ch_entry_t {valid, id, hops, qvalue}.
  - FSM state enum.
  - Constants HOPS_INVALID=16'hFFFF and Q_ONE=16'h4000.
  - Function ch_better(a,b) implementing the selection ordering, reused by SEARCH (inverted, for worst) and SELECT.
- One sub-module, kch_scan_cmp: single-cycle comparator wrapping ch_better, instantiated once and shared across both scans.

Test Plan:
- Basic insert: HB_reset with limit 3; insert 23/2/0x3000 → after 2*MAX_CH+2 cycles chosenCH=23, hopsfromCH=2, ch_count=1, kch_update pulse. Then insert 45/2/0x2000 → chosenCH stays 23, ch_count=2.
- Better CH: insert 12/1/0x4000 → chosenCH=12, chosenQ=0x4000, ch_count=3.
- Full table: insert 6/1/0x4000 → without KCH_EVICT_EN: kch_drop, chosenCH=12. With it: entry 45 evicted, chosenCH=6 (lower-ID tie-break), ch_count=3.
- In-place update: insert 23/1/0x7000 → chosenCH=23, hopsfromCH=1, ch_count unchanged. Re-send 12/1/0x4000 → no count change.
- Handshake: en_KCH during busy → kch_drop, table unchanged. fCH_Hops=0xFFFF → kch_drop, no busy.
- Abort/reset: HB_reset mid-SEARCH → next cycle busy=0, ch_count=0, chosenCH=0, hopsfromCH=0xFFFF, kch_valid=0. nrst low mid-SELECT → same values.
